ps2_kbd_rx: RTL

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_rx_frame.sv | 116 +++++++++++
 rtl/ps2_kbd_rx.sv | 73 +++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and byte/frame helpers for the PS/2 keyboard receiver.
// Consumed by ps2_rx_frame and ps2_kbd_rx.
package ps2_pkg;

    localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0]  PS2_PREFIX_REL = 8'hF0;
    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam logic [3:0]  PS2_LAST_BIT   = 4'(PS2_FRAME_BITS - 1);

    typedef enum logic [1:0] {
        BYTE_CODE = 2'd0,
        BYTE_EXT  = 2'd1,
        BYTE_REL  = 2'd2
    } byte_kind_e;

    // Odd parity across data and parity bit, plus a high stop bit.
    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return (^{data, par}) & stop;
    endfunction

    function automatic byte_kind_e classify(input logic [7:0] b);
        byte_kind_e kind;
        case (b)
            PS2_PREFIX_EXT: kind = BYTE_EXT;
            PS2_PREFIX_REL: kind = BYTE_REL;
            default:        kind = BYTE_CODE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, 11-bit deserializer, parity/stop check.
// Optional inactivity timeout is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       err
);

    logic       clk_meta_r;
    logic       clk_sync_r;
    logic       clk_prev_r;
    logic       data_meta_r;
    logic       data_sync_r;
    logic       fall_s;
    logic       timeout_s;
    logic [3:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       parity_r;

    // Two-stage synchronizers plus a third clock stage for edge detection.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            clk_prev_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            clk_prev_r  <= clk_sync_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    assign fall_s = clk_prev_r & ~clk_sync_r;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_r;

    assign timeout_s = (bit_cnt_r != 4'd0) && !fall_s && (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));

    // Idle-time counter, only running while a frame is partially received.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            to_cnt_r <= '0;
        end else if (fall_s || (bit_cnt_r == 4'd0) || timeout_s) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Deserializer: bit 0 start, 1..8 data LSB first, 9 parity, 10 stop.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            parity_r   <= 1'b0;
            byte_valid <= 1'b0;
            rx_byte    <= 8'h00;
            err        <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            err        <= 1'b0;
            if (timeout_s) begin
                bit_cnt_r <= 4'd0;
                err       <= 1'b1;
            end else if (fall_s) begin
                case (bit_cnt_r)
                    4'd0: begin
                        // A high start bit is noise: stay idle silently.
                        if (!data_sync_r) begin
                            bit_cnt_r <= 4'd1;
                        end else begin
                            bit_cnt_r <= 4'd0;
                        end
                    end
                    4'd9: begin
                        parity_r  <= data_sync_r;
                        bit_cnt_r <= 4'd10;
                    end
                    PS2_LAST_BIT: begin
                        bit_cnt_r <= 4'd0;
                        if (frame_ok(shift_r, parity_r, data_sync_r)) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shift_r;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: begin
                        shift_r   <= {data_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end
                endcase
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver top: strips E0/F0 prefixes into key_ext/key_pressed.
// Define PS2_RX_TIMEOUT_EN to abandon stalled partial frames after TIMEOUT_CYC cycles.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_pressed,
    output logic       frame_err
);

    logic       byte_valid_s;
    logic [7:0] rx_byte_s;
    logic       byte_err_s;
    logic       ext_flag_r;
    logic       rel_flag_r;

    ps2_rx_frame #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid_s),
        .rx_byte    (rx_byte_s),
        .err        (byte_err_s)
    );

    // Prefix decoder; a framing error drops any pending prefixes.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ext_flag_r  <= 1'b0;
            rel_flag_r  <= 1'b0;
            key_strobe  <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_pressed <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            frame_err  <= byte_err_s;
            if (byte_err_s) begin
                ext_flag_r <= 1'b0;
                rel_flag_r <= 1'b0;
            end else if (byte_valid_s) begin
                case (classify(rx_byte_s))
                    BYTE_EXT: ext_flag_r <= 1'b1;
                    BYTE_REL: rel_flag_r <= 1'b1;
                    default: begin
                        key_strobe  <= 1'b1;
                        key_code    <= rx_byte_s;
                        key_ext     <= ext_flag_r;
                        key_pressed <= ~rel_flag_r;
                        ext_flag_r  <= 1'b0;
                        rel_flag_r  <= 1'b0;
                    end
                endcase
            end else begin
                ext_flag_r <= ext_flag_r;
                rel_flag_r <= rel_flag_r;
            end
        end
    end

endmodule
